// File: rtl/map_read_arbiter.sv
// -----------------------------------------------------------------------------
// map_read_arbiter
//
// Purpose:
//   Shares the single synchronous read port of the tile map RAM between
//   NUM_REQ requesters, such as the per-player obstacle checkers, the
//   bomb/blast logic and the renderer.
//   - A round-robin arbiter accepts at most one lookup per cycle through a
//     valid/ready handshake.
//   - Each accepted lookup is tagged with its requester id and an
//     out-of-range flag.
//   - The tag travels down a pipeline that lines up with the RAM read data,
//     so every response comes back to its owner after a fixed
//     RD_LATENCY+1 cycles, in issue order.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous, active-high reset
//   req_valid   in   [NUM_REQ]            per-requester lookup request
//   req_addr    in   [NUM_REQ*ADDR_WIDTH] packed tile indices, requester i at
//                                         [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready   out  [NUM_REQ]            one-hot grant (handshake = valid & ready)
//   rsp_valid   out  [NUM_REQ]            one-hot owner of rsp_data this cycle
//   rsp_data    out  [DATA_W]             returned tile code (shared bus)
//   map_addr    out  [ADDR_WIDTH]         address to the map RAM
//   map_mem_in  in   [DATA_W]             map RAM read data
//   busy        out  any lookup in flight
// -----------------------------------------------------------------------------
module map_read_arbiter #(
  parameter int                NUM_REQ    = 3,
  parameter int                NUM_ROW    = 11,
  parameter int                NUM_COL    = 19,
  parameter int                DATA_W     = 2,
  parameter int                ADDR_WIDTH = $clog2(NUM_ROW * NUM_COL),
  parameter int                RD_LATENCY = 2,
  parameter logic [DATA_W-1:0] OOB_DATA   = 2'b01
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic [ADDR_WIDTH-1:0]         map_addr,
  input  logic [DATA_W-1:0]             map_mem_in,
  output logic                          busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int DEPTH = NUM_ROW * NUM_COL;
  localparam int LAST  = RD_LATENCY;

  // The depth is compared one bit wider than the address, so the
  // comparison stays correct even when DEPTH equals 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] map_addr_q, map_addr_d;

  logic [LAST:0]         tag_vld_q;
  logic [LAST:0]         tag_oob_q;
  logic [PTR_W-1:0]      tag_id_q [0:LAST];

  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  win_oob;
  logic                  handshake;

  // Adds a step of less than NUM_REQ to a requester index, modulo NUM_REQ.
  // A single conditional subtract is enough because both operands are
  // below NUM_REQ.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return PTR_W'(sum);
  endfunction

  // Round-robin search that starts at the pointer.
  // The loop runs from the farthest candidate back to the pointer itself,
  // so the last match written is the nearest valid requester. That nearest
  // requester is the round-robin winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  // Picks the winner's address out of the packed request bus and flags it
  // when it lies outside the map.
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    win_oob = ({1'b0, win_addr} >= DEPTH_EXT);
  end

  // The grant is always given to a valid requester, so finding a winner is
  // the same as completing a handshake this cycle.
  assign handshake = win_found;

  // One-hot ready at the winner; all zero when nobody is asking.
  always_comb begin
    req_ready = '0;
    if (win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Next-state logic for the pointer and the RAM address.
  // - On a handshake, the pointer moves just past the winner, which gives
  //   each requester a fair turn.
  // - The RAM address only moves for in-range lookups. An out-of-range
  //   lookup never reaches the RAM; its answer is substituted at the
  //   response side.
  always_comb begin
    ptr_d      = ptr_q;
    map_addr_d = map_addr_q;
    if (handshake) begin
      ptr_d = wrap_add(win_idx, 1);
      if (!win_oob) begin
        map_addr_d = win_addr;
      end
    end
  end

  // State registers and the tag pipeline.
  // - Stage 0 is written with the accepted lookup, and every stage shifts
  //   forward each cycle.
  // - The last stage lines up with the RAM data, which arrives RD_LATENCY
  //   cycles after the address.
  // - Reset drops every in-flight tag, so a lookup that was in progress
  //   never produces a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      map_addr_q <= '0;
      tag_vld_q  <= '0;
      tag_oob_q  <= '0;
      for (int i = 0; i <= LAST; i++) begin
        tag_id_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      map_addr_q  <= map_addr_d;
      tag_vld_q   <= {tag_vld_q[LAST-1:0], handshake};
      tag_oob_q   <= {tag_oob_q[LAST-1:0], handshake & win_oob};
      tag_id_q[0] <= win_idx;
      for (int i = 1; i <= LAST; i++) begin
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  // Response side.
  // - The response is decoded combinationally from the last tag stage.
  // - The data is the RAM word, unless the lookup was out of range; in that
  //   case the fixed OOB_DATA code is returned instead.
  always_comb begin
    rsp_valid = '0;
    if (tag_vld_q[LAST]) begin
      rsp_valid[tag_id_q[LAST]] = 1'b1;
    end
    rsp_data = tag_oob_q[LAST] ? OOB_DATA : map_mem_in;
  end

  assign map_addr = map_addr_q;
  assign busy     = |tag_vld_q;

endmodule

// File: tb/tb_map_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_map_read_arbiter
//
// Purpose:
//   Self-checking bench for map_read_arbiter at its default parameters.
//   - A small two-stage registered RAM model sits behind map_addr and
//     returns mem[a] = a[1:0] ^ a[3:2].
//   - Each test task drives requests and compares grants and addresses
//     inline.
//   - Every expected response is pushed to a scoreboard queue when its
//     request is driven. A response monitor pops and compares it in the
//     cycle the DUT should answer.
// -----------------------------------------------------------------------------
module tb_map_read_arbiter;

  localparam int NUM_REQ = 3;
  localparam int AW      = 8;
  localparam int DW      = 2;
  localparam int DEPTH   = 209;
  localparam int LAT     = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_REQ-1:0]      req_valid = '0;
  logic [NUM_REQ*AW-1:0]   req_addr = '0;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [DW-1:0]           rsp_data;
  logic [AW-1:0]           map_addr;
  logic [DW-1:0]           map_mem_in = '0;
  logic [DW-1:0]           memStage1 = '0;
  logic                    busy;

  int                      checks = 0;
  int                      failures = 0;
  int                      cyc = 0;
  logic                    monEn = 1'b0;
  logic [AW-1:0]           lastAddr = '0;
  logic [NUM_REQ-1:0]      monExpV;
  logic [DW-1:0]           monExpD;
  logic                    monExpB;

  typedef struct {
    int                 due;
    logic [NUM_REQ-1:0] id;
    logic [DW-1:0]      data;
  } expT;

  expT sbq[$];

  map_read_arbiter #(
    .NUM_REQ    (3),
    .NUM_ROW    (11),
    .NUM_COL    (19),
    .DATA_W     (2),
    .ADDR_WIDTH (8),
    .RD_LATENCY (2),
    .OOB_DATA   (2'b01)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .map_addr   (map_addr),
    .map_mem_in (map_mem_in),
    .busy       (busy)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memModel(input logic [AW-1:0] a);
    return a[1:0] ^ a[3:2];
  endfunction

  // Two-stage registered map RAM plus a cycle counter used to time
  // scoreboard entries.
  always @(posedge clk) begin
    memStage1  <= memModel(map_addr);
    map_mem_in <= memStage1;
    cyc        <= cyc + 1;
  end

  // Response monitor.
  // - It samples a few ns after the falling edge, behind the stimulus drive
  //   and the scoreboard push.
  // - busy is expected while the oldest entry is within two cycles of its
  //   due cycle.
  // - The response itself is expected exactly on the due cycle.
  always @(negedge clk) begin
    #3;
    if (monEn) begin
      monExpV = '0;
      monExpD = '0;
      monExpB = 1'b0;
      if (sbq.size() > 0) begin
        if (sbq[0].due <= cyc + 2) monExpB = 1'b1;
        if (sbq[0].due == cyc) begin
          monExpV = sbq[0].id;
          monExpD = sbq[0].data;
          sbq.delete(0);
        end
      end
      checks++;
      if (rsp_valid !== monExpV) begin
        failures++;
        $display("[TB] FAIL rsp_valid cyc=%0d got %b expected %b", cyc, rsp_valid, monExpV);
      end
      if (monExpV != '0) begin
        checks++;
        if (rsp_data !== monExpD) begin
          failures++;
          $display("[TB] FAIL rsp_data cyc=%0d got %b expected %b", cyc, rsp_data, monExpD);
        end
      end
      checks++;
      if (busy !== monExpB) begin
        failures++;
        $display("[TB] FAIL busy cyc=%0d got %b expected %b", cyc, busy, monExpB);
      end
    end
  end

  // Drives one cycle of requests on the falling edge, then lets the
  // combinational grant settle.
  task automatic driveReq(input logic [2:0] v, input logic [7:0] a0,
                          input logic [7:0] a1, input logic [7:0] a2);
    @(negedge clk);
    req_valid = v;
    req_addr  = {a2, a1, a0};
    #1;
  endtask

  // Records the expected response for the lookup the bench expects to be
  // granted this cycle.
  task automatic pushExpected(input logic [2:0] grant);
    expT         e;
    logic [7:0]  a;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a      = req_addr[i*AW +: AW];
        e.due  = cyc + LAT;
        e.id   = grant;
        e.data = (int'(a) >= DEPTH) ? 2'b01 : memModel(a);
        if (int'(a) < DEPTH) lastAddr = a;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    monEn = 1'b0;
    sbq.delete();
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_ready got %b expected 000", req_ready);
    end
    checks++;
    if (rsp_valid !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_rsp_valid got %b expected 000", rsp_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_busy got %b expected 0", busy);
    end
    checks++;
    if (map_addr !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_map_addr got %0d expected 0", map_addr);
    end
    @(negedge clk);
    rst   = 1'b0;
    monEn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      driveReq(3'b000, 8'd0, 8'd0, 8'd0);
      checks++;
      if (req_ready !== 3'b000 || rsp_valid !== 3'b000 || busy !== 1'b0 || map_addr !== 8'd0) begin
        failures++;
        $display("[TB] FAIL idle_after_reset i=%0d got ready=%b rsp=%b busy=%b addr=%0d expected 000/000/0/0",
                 i, req_ready, rsp_valid, busy, map_addr);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] expG [6];
    logic [7:0] expAddr [6];
    expG    = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    expAddr = '{8'd20, 8'd21, 8'd22, 8'd20, 8'd21, 8'd22};
    for (int i = 0; i < 6; i++) begin
      driveReq(3'b111, 8'd20, 8'd21, 8'd22);
      checks++;
      if (req_ready !== expG[i]) begin
        failures++;
        $display("[TB] FAIL b2b_grant i=%0d got %b expected %b", i, req_ready, expG[i]);
      end
      if (i > 0) begin
        checks++;
        if (map_addr !== expAddr[i-1]) begin
          failures++;
          $display("[TB] FAIL b2b_map_addr i=%0d got %0d expected %0d", i, map_addr, expAddr[i-1]);
        end
      end
      pushExpected(expG[i]);
    end
    for (int i = 0; i < 5; i++) driveReq(3'b000, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic test_single;
    driveReq(3'b010, 8'd0, 8'd40, 8'd0);
    checks++;
    if (req_ready !== 3'b010) begin
      failures++;
      $display("[TB] FAIL single_grant got %b expected 010", req_ready);
    end
    pushExpected(3'b010);
    driveReq(3'b000, 8'd0, 8'd0, 8'd0);
    checks++;
    if (map_addr !== 8'd40) begin
      failures++;
      $display("[TB] FAIL single_map_addr got %0d expected 40", map_addr);
    end
    driveReq(3'b000, 8'd0, 8'd0, 8'd0);
    driveReq(3'b000, 8'd0, 8'd0, 8'd0);
    checks++;
    if (rsp_valid !== 3'b010 || rsp_data !== 2'b10) begin
      failures++;
      $display("[TB] FAIL single_rsp got valid=%b data=%b expected 010/10", rsp_valid, rsp_data);
    end
    for (int i = 0; i < 2; i++) driveReq(3'b000, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic test_wrap;
    driveReq(3'b101, 8'd5, 8'd0, 8'd7);
    checks++;
    if (req_ready !== 3'b100) begin
      failures++;
      $display("[TB] FAIL wrap_grant_first got %b expected 100", req_ready);
    end
    pushExpected(3'b100);
    driveReq(3'b001, 8'd5, 8'd0, 8'd0);
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("[TB] FAIL wrap_grant_second got %b expected 001", req_ready);
    end
    checks++;
    if (map_addr !== 8'd7) begin
      failures++;
      $display("[TB] FAIL wrap_map_addr_first got %0d expected 7", map_addr);
    end
    pushExpected(3'b001);
    driveReq(3'b000, 8'd0, 8'd0, 8'd0);
    checks++;
    if (map_addr !== 8'd5) begin
      failures++;
      $display("[TB] FAIL wrap_map_addr_second got %0d expected 5", map_addr);
    end
    for (int i = 0; i < 4; i++) driveReq(3'b000, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic test_oob;
    driveReq(3'b001, 8'd208, 8'd0, 8'd0);
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("[TB] FAIL oob_grant_last_tile got %b expected 001", req_ready);
    end
    pushExpected(3'b001);
    driveReq(3'b001, 8'd209, 8'd0, 8'd0);
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("[TB] FAIL oob_grant_depth got %b expected 001", req_ready);
    end
    checks++;
    if (map_addr !== 8'd208) begin
      failures++;
      $display("[TB] FAIL oob_map_addr_last_tile got %0d expected 208", map_addr);
    end
    pushExpected(3'b001);
    driveReq(3'b000, 8'd0, 8'd0, 8'd0);
    checks++;
    if (map_addr !== lastAddr) begin
      failures++;
      $display("[TB] FAIL oob_map_addr_held got %0d expected %0d", map_addr, lastAddr);
    end
    driveReq(3'b000, 8'd0, 8'd0, 8'd0);
    driveReq(3'b000, 8'd0, 8'd0, 8'd0);
    checks++;
    if (rsp_valid !== 3'b001 || rsp_data !== 2'b01) begin
      failures++;
      $display("[TB] FAIL oob_rsp got valid=%b data=%b expected 001/01", rsp_valid, rsp_data);
    end
    for (int i = 0; i < 3; i++) driveReq(3'b000, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic test_reset_mid;
    driveReq(3'b010, 8'd0, 8'd12, 8'd0);
    checks++;
    if (req_ready !== 3'b010) begin
      failures++;
      $display("[TB] FAIL rstmid_grant_a got %b expected 010", req_ready);
    end
    pushExpected(3'b010);
    driveReq(3'b001, 8'd13, 8'd0, 8'd0);
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("[TB] FAIL rstmid_grant_b got %b expected 001", req_ready);
    end
    pushExpected(3'b001);
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b1;
    sbq.delete();
    #1;
    checks++;
    if (rsp_valid !== 3'b000 || busy !== 1'b0 || map_addr !== 8'd0) begin
      failures++;
      $display("[TB] FAIL rstmid_in_reset got rsp=%b busy=%b addr=%0d expected 000/0/0",
               rsp_valid, busy, map_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      driveReq(3'b000, 8'd0, 8'd0, 8'd0);
      checks++;
      if (rsp_valid !== 3'b000 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rstmid_quiet i=%0d got rsp=%b busy=%b expected 000/0", i, rsp_valid, busy);
      end
    end
    driveReq(3'b111, 8'd30, 8'd31, 8'd32);
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("[TB] FAIL rstmid_ptr_cleared got %b expected 001", req_ready);
    end
    pushExpected(3'b001);
    for (int i = 0; i < 5; i++) driveReq(3'b000, 8'd0, 8'd0, 8'd0);
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_single;
    test_wrap;
    test_oob;
    test_reset_mid;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_drain got %0d pending responses expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
